// File: rtl/block_ram_arbiter.sv
// block_ram_arbiter
//   Shares one block_ram TileLink-UL port between instruction fetch (port 0)
//   and data load/store (port 1). One grant per cycle, round-robin on
//   conflicts, fixed one-cycle response latency. Addresses outside the RAM
//   window are answered locally with an error and never reach the RAM.
//
// Ports
//   clock     : global clock, rising edge
//   reset_n   : asynchronous active-low reset
//   req0_tla  : requester 0 (fetch) A channel
//   req0_tld  : requester 0 D channel; d_ready means "A accepted this cycle"
//   req1_tla  : requester 1 (data) A channel
//   req1_tld  : requester 1 D channel; d_ready means "A accepted this cycle"
//   ram_tla   : A channel towards block_ram
//   ram_tld   : D channel from block_ram, one cycle after a_valid
//
// Optional feature (define BLOCK_RAM_ARBITER_STATS_EN)
//   grant0_count, grant1_count : grants per port, wrap at 2^32
//   conflict_count             : cycles with both requesters valid

package block_ram_arbiter_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [3:0]  d_source;
    logic        d_error;
    logic [31:0] d_data;
    logic        d_ready;
  } tilelink_d;

  localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_A_GET             = 3'd4;
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

endpackage

module block_ram_arbiter
  import block_ram_arbiter_pkg::*;
#(
  parameter logic [31:0] addr_mask = 32'hF000_0000,
  parameter logic [31:0] addr_tag  = 32'h0000_0000
) (
  input  logic      clock,
  input  logic      reset_n,
  input  tilelink_a req0_tla,
  output tilelink_d req0_tld,
  input  tilelink_a req1_tla,
  output tilelink_d req1_tld,
  output tilelink_a ram_tla,
  input  tilelink_d ram_tld
`ifdef BLOCK_RAM_ARBITER_STATS_EN
  ,
  output logic [31:0] grant0_count,
  output logic [31:0] grant1_count,
  output logic [31:0] conflict_count
`endif
);

  logic       valid0;
  logic       valid1;
  logic       hit0;
  logic       hit1;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic       win_hit;
  tilelink_a  win_tla;
  tilelink_d  rsp;

  // last_grant holds the index of the port granted most recently
  logic       last_grant;
  logic       inflight_valid;
  logic       inflight_owner;
  logic       inflight_err;
  logic [3:0] inflight_source;

  // The RAM's own valid/source/ready are not needed: the response slot is
  // tracked locally, so a RAM answer with no matching slot is simply ignored.
  logic       unused_ram_fields;
  assign unused_ram_fields = ^{ram_tld.d_valid, ram_tld.d_source, ram_tld.d_ready};

  // Requests are masked while reset is asserted so nothing is granted or
  // forwarded to the RAM during reset.
  assign valid0 = reset_n && req0_tla.a_valid;
  assign valid1 = reset_n && req1_tla.a_valid;
  assign hit0   = ((req0_tla.a_address & addr_mask) == addr_tag);
  assign hit1   = ((req1_tla.a_address & addr_mask) == addr_tag);

  // Port 1 wins when it is alone, or on a conflict when port 0 was granted last.
  assign grant1  = valid1 && (!valid0 || !last_grant);
  assign grant0  = valid0 && !grant1;
  assign accept  = grant0 || grant1;
  assign win_tla = grant1 ? req1_tla : req0_tla;
  assign win_hit = grant1 ? hit1 : hit0;

  // Only decoded hits are forwarded; misses are answered locally next cycle.
  always_comb begin
    ram_tla         = win_tla;
    ram_tla.a_valid = accept && win_hit;
  end

  // Remember who was granted and how the response must be formed one cycle later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant      <= 1'b1;
      inflight_valid  <= 1'b0;
      inflight_owner  <= 1'b0;
      inflight_err    <= 1'b0;
      inflight_source <= 4'd0;
    end else begin
      inflight_valid <= accept;
      if (accept) begin
        last_grant      <= grant1;
        inflight_owner  <= grant1;
        inflight_err    <= !win_hit;
        inflight_source <= win_tla.a_source;
      end
    end
  end

  // Build the response for the owner of the in-flight slot; the other port
  // sees an idle D channel. d_ready reflects this cycle's A acceptance.
  always_comb begin
    rsp = '0;
    if (inflight_valid) begin
      rsp.d_valid  = 1'b1;
      rsp.d_source = inflight_source;
      if (inflight_err) begin
        rsp.d_opcode = TL_D_ACCESS_ACK_DATA;
        rsp.d_error  = 1'b1;
      end else begin
        rsp.d_opcode = ram_tld.d_opcode;
        rsp.d_param  = ram_tld.d_param;
        rsp.d_size   = ram_tld.d_size;
        rsp.d_data   = ram_tld.d_data;
        rsp.d_error  = ram_tld.d_error;
      end
    end
    req0_tld         = inflight_owner ? '0 : rsp;
    req1_tld         = inflight_owner ? rsp : '0;
    req0_tld.d_ready = grant0;
    req1_tld.d_ready = grant1;
  end

`ifdef BLOCK_RAM_ARBITER_STATS_EN
  // Grant and conflict statistics, each counted on the edge closing the cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant0_count   <= 32'd0;
      grant1_count   <= 32'd0;
      conflict_count <= 32'd0;
    end else begin
      if (grant0) begin
        grant0_count <= grant0_count + 32'd1;
      end
      if (grant1) begin
        grant1_count <= grant1_count + 32'd1;
      end
      if (valid0 && valid1) begin
        conflict_count <= conflict_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_block_ram_arbiter.sv
// tb_block_ram_arbiter
//   Self-checking bench for block_ram_arbiter: a simple block_ram stand-in
//   answers the RAM port, and a reference model tracks fairness, expected
//   responses and memory contents at transaction level.

module tb_block_ram_arbiter;
  import block_ram_arbiter_pkg::*;

  logic      clock;
  logic      reset_n;
  tilelink_a req0_tla;
  tilelink_d req0_tld;
  tilelink_a req1_tla;
  tilelink_d req1_tld;
  tilelink_a ram_tla;
  tilelink_d ram_tld;
`ifdef BLOCK_RAM_ARBITER_STATS_EN
  logic [31:0] grant0_count;
  logic [31:0] grant1_count;
  logic [31:0] conflict_count;
`endif

  int total_checks = 0;
  int bad_checks   = 0;

  block_ram_arbiter dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req0_tla (req0_tla),
    .req0_tld (req0_tld),
    .req1_tla (req1_tla),
    .req1_tld (req1_tld),
    .ram_tla  (ram_tla),
    .ram_tld  (ram_tld)
`ifdef BLOCK_RAM_ARBITER_STATS_EN
    ,
    .grant0_count   (grant0_count),
    .grant1_count   (grant1_count),
    .conflict_count (conflict_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Block RAM stand-in: 256 words, answers every forwarded request one cycle later.
  logic [31:0] ram_mem [0:255];

  always @(posedge clock) begin
    if (ram_tla.a_valid) begin
      ram_tld.d_valid  <= 1'b1;
      ram_tld.d_param  <= 2'd0;
      ram_tld.d_size   <= ram_tla.a_size;
      ram_tld.d_source <= ram_tla.a_source;
      ram_tld.d_error  <= 1'b0;
      ram_tld.d_ready  <= 1'b0;
      if (ram_tla.a_opcode == TL_A_GET) begin
        ram_tld.d_opcode <= TL_D_ACCESS_ACK_DATA;
        ram_tld.d_data   <= ram_mem[ram_tla.a_address[9:2]];
      end else begin
        ram_tld.d_opcode <= TL_D_ACCESS_ACK;
        ram_tld.d_data   <= 32'd0;
        for (int b = 0; b < 4; b++) begin
          if (ram_tla.a_mask[b]) begin
            ram_mem[ram_tla.a_address[9:2]][8*b +: 8] <= ram_tla.a_data[8*b +: 8];
          end
        end
      end
    end else begin
      ram_tld <= '0;
    end
  end

  // Reference model state: memory image, last granted port, response due now.
  logic [31:0] model_mem [0:255];
  int          model_last;
  bit          exp_valid;
  int          exp_port;
  bit          exp_err;
  logic [3:0]  exp_source;
  logic [2:0]  exp_opcode;
  logic [31:0] exp_data;
  logic [1:0]  exp_size;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    model_last = 1;
    exp_valid  = 1'b0;
    exp_port   = 0;
    exp_err    = 1'b0;
  endtask

  function automatic tilelink_a mkReq(input logic [2:0] op, input logic [31:0] addr,
                                      input logic [3:0] mask, input logic [31:0] data,
                                      input logic [3:0] src);
    tilelink_a r;
    r           = '0;
    r.a_valid   = 1'b1;
    r.a_opcode  = op;
    r.a_size    = 2'd2;
    r.a_source  = src;
    r.a_address = addr;
    r.a_mask    = mask;
    r.a_data    = data;
    return r;
  endfunction

  function automatic tilelink_a randomReq();
    tilelink_a   r;
    int          kind;
    logic [31:0] addr;
    kind = $urandom_range(0, 2);
    addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    if ($urandom_range(0, 9) == 0) begin
      addr[31:28] = 4'($urandom_range(1, 15));
    end
    case (kind)
      0:       r = mkReq(TL_A_GET, addr, 4'hF, 32'd0, 4'($urandom_range(0, 15)));
      1:       r = mkReq(TL_A_PUT_FULL, addr, 4'hF, $urandom, 4'($urandom_range(0, 15)));
      default: r = mkReq(TL_A_PUT_PARTIAL, addr, 4'($urandom_range(1, 15)), $urandom,
                         4'($urandom_range(0, 15)));
    endcase
    return r;
  endfunction

  // One bus cycle: drive both A channels, check every output against the
  // model mid-cycle, then advance the model as if the clock edge happened.
  task automatic applyStimulus(input tilelink_a a0, input tilelink_a a1, output int win);
    int          pick;
    tilelink_a   w;
    tilelink_d   obs;
    bit          in_window;
    int          idx;
    req0_tla = a0;
    req1_tla = a1;
    @(negedge clock);

    checkOutput("d_valid0", 32'(req0_tld.d_valid), 32'(exp_valid && exp_port == 0));
    checkOutput("d_valid1", 32'(req1_tld.d_valid), 32'(exp_valid && exp_port == 1));
    if (exp_valid) begin
      obs = (exp_port == 0) ? req0_tld : req1_tld;
      checkOutput("d_source", 32'(obs.d_source), 32'(exp_source));
      checkOutput("d_error", 32'(obs.d_error), 32'(exp_err));
      checkOutput("d_opcode", 32'(obs.d_opcode), 32'(exp_opcode));
      checkOutput("d_data", obs.d_data, exp_data);
      if (!exp_err) begin
        checkOutput("d_size", 32'(obs.d_size), 32'(exp_size));
      end
    end

    // Round robin: a lone requester wins; on conflict the port not granted last wins.
    if (a0.a_valid && a1.a_valid) begin
      pick = (model_last == 0) ? 1 : 0;
    end else if (a0.a_valid) begin
      pick = 0;
    end else if (a1.a_valid) begin
      pick = 1;
    end else begin
      pick = -1;
    end
    checkOutput("d_ready0", 32'(req0_tld.d_ready), 32'(pick == 0));
    checkOutput("d_ready1", 32'(req1_tld.d_ready), 32'(pick == 1));

    w         = (pick == 1) ? a1 : a0;
    in_window = (w.a_address[31:28] == 4'h0);
    checkOutput("ram_a_valid", 32'(ram_tla.a_valid), 32'(pick >= 0 && in_window));
    if (pick >= 0 && in_window) begin
      checkOutput("ram_a_address", ram_tla.a_address, w.a_address);
      checkOutput("ram_a_opcode", 32'(ram_tla.a_opcode), 32'(w.a_opcode));
    end

    if (pick >= 0) begin
      model_last = pick;
      exp_valid  = 1'b1;
      exp_port   = pick;
      exp_err    = !in_window;
      exp_source = w.a_source;
      exp_size   = w.a_size;
      exp_data   = 32'd0;
      idx        = int'(w.a_address[9:2]);
      if (!in_window) begin
        exp_opcode = TL_D_ACCESS_ACK_DATA;
      end else if (w.a_opcode == TL_A_GET) begin
        exp_opcode = TL_D_ACCESS_ACK_DATA;
        exp_data   = model_mem[idx];
      end else begin
        exp_opcode = TL_D_ACCESS_ACK;
        for (int b = 0; b < 4; b++) begin
          if (w.a_mask[b]) begin
            model_mem[idx][8*b +: 8] = w.a_data[8*b +: 8];
          end
        end
      end
    end else begin
      exp_valid = 1'b0;
    end

    @(posedge clock);
    #1;
    win = pick;
  endtask

  initial begin
    tilelink_a idle;
    tilelink_a g0;
    tilelink_a g1;
    tilelink_a p0;
    tilelink_a p1;
    int        w;

    idle = '0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i]   = (32'(i) * 32'h0100_0193) ^ 32'h5A5A_0000;
      model_mem[i] = (32'(i) * 32'h0100_0193) ^ 32'h5A5A_0000;
    end
    modelReset();

    // Reset: a pending request must not be granted or forwarded.
    reset_n  = 1'b0;
    req0_tla = mkReq(TL_A_GET, 32'h10, 4'hF, 32'd0, 4'd1);
    req1_tla = mkReq(TL_A_GET, 32'h14, 4'hF, 32'd0, 4'd2);
    #12;
    checkOutput("rst_d_valid0", 32'(req0_tld.d_valid), 32'd0);
    checkOutput("rst_d_valid1", 32'(req1_tld.d_valid), 32'd0);
    checkOutput("rst_d_error0", 32'(req0_tld.d_error), 32'd0);
    checkOutput("rst_d_ready0", 32'(req0_tld.d_ready), 32'd0);
    checkOutput("rst_d_ready1", 32'(req1_tld.d_ready), 32'd0);
    checkOutput("rst_ram_valid", 32'(ram_tla.a_valid), 32'd0);
    @(posedge clock);
    #1;
    reset_n  = 1'b1;
    req0_tla = idle;
    req1_tla = idle;

    // Write then read back a word through port 0.
    applyStimulus(mkReq(TL_A_PUT_FULL, 32'h10, 4'hF, 32'hDEAD_BEEF, 4'd0), idle, w);
    applyStimulus(mkReq(TL_A_GET, 32'h10, 4'hF, 32'd0, 4'd1), idle, w);
    checkOutput("get_grant", 32'(w), 32'd0);
    checkOutput("get_valid0", 32'(req0_tld.d_valid), 32'd1);
    checkOutput("get_data", req0_tld.d_data, 32'hDEAD_BEEF);
    checkOutput("get_source", 32'(req0_tld.d_source), 32'd1);
    checkOutput("get_error", 32'(req0_tld.d_error), 32'd0);
    checkOutput("get_valid1", 32'(req1_tld.d_valid), 32'd0);

    // Partial write from port 1 immediately followed by a read from port 0.
    applyStimulus(idle, mkReq(TL_A_PUT_FULL, 32'h20, 4'hF, 32'h1234_5678, 4'd2), w);
    applyStimulus(idle, mkReq(TL_A_PUT_PARTIAL, 32'h20, 4'b0011, 32'h0000_ABCD, 4'd3), w);
    applyStimulus(mkReq(TL_A_GET, 32'h20, 4'hF, 32'd0, 4'd4), idle, w);
    checkOutput("merge_data", req0_tld.d_data, 32'h1234_ABCD);

    // Out-of-window access is answered locally with an error.
    applyStimulus(idle, mkReq(TL_A_GET, 32'h3000_0000, 4'hF, 32'd0, 4'd5), w);
    checkOutput("err_valid", 32'(req1_tld.d_valid), 32'd1);
    checkOutput("err_error", 32'(req1_tld.d_error), 32'd1);
    checkOutput("err_opcode", 32'(req1_tld.d_opcode), 32'(TL_D_ACCESS_ACK_DATA));
    checkOutput("err_data", req1_tld.d_data, 32'd0);

    // Both ports request every cycle: grants must alternate starting at port 0.
    g0 = mkReq(TL_A_GET, 32'h40, 4'hF, 32'd0, 4'd6);
    g1 = mkReq(TL_A_GET, 32'h44, 4'hF, 32'd0, 4'd7);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(g0, g1, w);
      checkOutput("alt_grant", 32'(w), 32'(i % 2));
    end
    applyStimulus(idle, idle, w);

    // Reset pulse while a response is being presented.
    applyStimulus(mkReq(TL_A_GET, 32'h10, 4'hF, 32'd0, 4'd8), idle, w);
    req0_tla = g0;
    req1_tla = g1;
    checkOutput("pre_rst_valid", 32'(req0_tld.d_valid), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid0", 32'(req0_tld.d_valid), 32'd0);
    checkOutput("mid_rst_valid1", 32'(req1_tld.d_valid), 32'd0);
    checkOutput("mid_rst_ready0", 32'(req0_tld.d_ready), 32'd0);
    checkOutput("mid_rst_ram", 32'(ram_tla.a_valid), 32'd0);
    #1;
    reset_n = 1'b1;
    modelReset();

    // Ten conflict cycles then three port-0-only cycles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(g0, g1, w);
      if (i == 0) begin
        checkOutput("post_rst_grant", 32'(w), 32'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(g0, idle, w);
    end
`ifdef BLOCK_RAM_ARBITER_STATS_EN
    checkOutput("grant0_count", grant0_count, 32'd8);
    checkOutput("grant1_count", grant1_count, 32'd5);
    checkOutput("conflict_count", conflict_count, 32'd10);
`endif

    // Random traffic; each requester holds its request until it is accepted.
    p0 = idle;
    p1 = idle;
    w  = -1;
    for (int i = 0; i < 600; i++) begin
      if (!p0.a_valid || w == 0) begin
        p0 = ($urandom_range(0, 3) != 0) ? randomReq() : idle;
      end
      if (!p1.a_valid || w == 1) begin
        p1 = ($urandom_range(0, 3) != 0) ? randomReq() : idle;
      end
      applyStimulus(p0, p1, w);
    end
    applyStimulus(idle, idle, w);
    applyStimulus(idle, idle, w);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
